ysyx_25060170_ifu_fsm: RTL and testbench

YSYX_25060170_IFU_FSM -- requirements
Module: ysyx_25060170_ifu_fsm

---
 rtl/ysyx_25060170_ifu_fsm.sv | 153 +++++++++++++++
 tb/tb_ysyx_25060170_ifu_fsm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_ifu_fsm.sv
// Instruction fetch sequencer: one outstanding imem request, one registered beat to IDU.
// Optional misaligned-redirect trap is enabled by defining YSYX_25060170_IFU_MISALIGN_CHK_EN.
module ysyx_25060170_ifu_fsm #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
  output logic            out_err,
`endif
  output logic [XLEN-1:0] pc
);

  // state | meaning
  // IDLE  | post-reset bubble, nothing valid
  // REQ   | request for pc presented to imem
  // WAIT  | request accepted, waiting for the response
  // HOLD  | fetched beat presented to IDU
  // DROP  | redirected with a response still in flight; discard it
  // ERR   | misaligned redirect trap beat (optional build only)
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
    , S_ERR
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [XLEN-1:0]   redir_pc;

`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
  logic err_valid_q, err_valid_d;
  logic enter_err;
  assign redir_pc = redirect_pc;
`else
  // Without the trap, low bits are simply cleared on load.
  assign redir_pc = redirect_pc & ~XLEN'(3);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
      err_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
      err_valid_q <= err_valid_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
    err_valid_d = err_valid_q;
    enter_err   = 1'b0;
`endif
    if (redirect_valid) begin
      pc_d = redir_pc;
      // DROP is needed only when an accepted request has not yet returned.
      if ((state_q == S_REQ && imem_req_ready) ||
          (state_q == S_WAIT && !imem_rsp_valid) ||
          (state_q == S_DROP)) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
        enter_err = |redirect_pc[1:0];
`endif
      end
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
      err_valid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  if (imem_req_ready) state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d    = S_HOLD;
            out_inst_d = imem_rsp_data;
            out_pc_d   = pc_q;
            pc_d       = pc_q + XLEN'(4);
          end
        end
        S_HOLD: if (out_ready) state_d = S_REQ;
        S_DROP: begin
          if (imem_rsp_valid) begin
            state_d = S_REQ;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
            enter_err = |pc_q[1:0];
`endif
          end
        end
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
        S_ERR: if (out_ready) err_valid_d = 1'b0;
`endif
        default: state_d = S_IDLE;
      endcase
    end
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
    if (enter_err) begin
      state_d     = S_ERR;
      out_pc_d    = pc_d;
      out_inst_d  = '0;
      err_valid_d = 1'b1;
    end
`endif
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign pc             = pc_q;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
  assign out_err   = (state_q == S_ERR) && err_valid_q;
  assign out_valid = (state_q == S_HOLD) || out_err;
`else
  assign out_valid = (state_q == S_HOLD);
`endif

endmodule

// File: tb/tb_ysyx_25060170_ifu_fsm.sv
// Directed bench for ysyx_25060170_ifu_fsm: cycle table plus throughput, reset and misalign sequences.
module tb_ysyx_25060170_ifu_fsm;
  localparam logic [31:0] P = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] pc;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
  logic        out_err;
`endif

  ysyx_25060170_ifu_fsm #(.XLEN(32), .RESET_PC(P)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
    .out_err(out_err),
`endif
    .pc(pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rsp;
    logic [31:0] rdata;
    logic        ordy;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_opc;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rv, logic [31:0] rpc, logic rdy, logic rsp, logic [31:0] rdata,
                              logic ordy, logic e_reqv, logic [31:0] e_addr, logic e_ov,
                              logic [31:0] e_opc, logic [31:0] e_inst, logic [31:0] e_pc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rsp = rsp; v.rdata = rdata; v.ordy = ordy;
    v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_opc = e_opc; v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic drive_idle();
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Expected values are the outputs seen before the row's inputs are applied.
    // inputs: rv rpc rdy rsp rdata ordy | expected: reqv addr ov out_pc out_inst pc
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          0, P, 0, 0, 0, P));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,                          1, P, 0, 0, 0, P));
    vecs.push_back(mk(0, 0, 0, 1, 32'h1111_0000, 0,              0, P, 0, 0, 0, P));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,                          0, P+4, 1, P, 32'h1111_0000, P+4));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,                          1, P+4, 0, P, 32'h1111_0000, P+4));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2222_0004, 0,              0, P+4, 0, P, 32'h1111_0000, P+4));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 1, 1, 0, 0,                        0, P+8, 1, P+4, 32'h2222_0004, P+8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,                          0, P+8, 1, P+4, 32'h2222_0004, P+8));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,                          1, P+8, 0, P+4, 32'h2222_0004, P+8));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3333_0008, 0,              0, P+8, 0, P+4, 32'h2222_0004, P+8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,                          0, P+12, 1, P+8, 32'h3333_0008, P+12));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,                          1, P+12, 0, P+8, 32'h3333_0008, P+12));
    vecs.push_back(mk(1, P+32'h100, 0, 0, 0, 0,                  0, P+12, 0, P+8, 32'h3333_0008, P+12));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          0, P+32'h100, 0, P+8, 32'h3333_0008, P+32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0,              0, P+32'h100, 0, P+8, 32'h3333_0008, P+32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, P+32'h100, 0, P+8, 32'h3333_0008, P+32'h100));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,                          1, P+32'h100, 0, P+8, 32'h3333_0008, P+32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 32'h4444_0100, 0,              0, P+32'h100, 0, P+8, 32'h3333_0008, P+32'h100));
    vecs.push_back(mk(1, P+32'h200, 0, 0, 0, 1,                  0, P+32'h104, 1, P+32'h100, 32'h4444_0100, P+32'h104));
    vecs.push_back(mk(1, P+32'h300, 0, 0, 0, 0,                  1, P+32'h200, 0, P+32'h100, 32'h4444_0100, P+32'h200));
    vecs.push_back(mk(1, P+32'h400, 1, 0, 0, 0,                  1, P+32'h300, 0, P+32'h100, 32'h4444_0100, P+32'h300));
    vecs.push_back(mk(1, P+32'h500, 0, 0, 0, 0,                  0, P+32'h400, 0, P+32'h100, 32'h4444_0100, P+32'h400));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0BAD_0BAD, 0,              0, P+32'h500, 0, P+32'h100, 32'h4444_0100, P+32'h500));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,                          1, P+32'h500, 0, P+32'h100, 32'h4444_0100, P+32'h500));
    vecs.push_back(mk(1, P+32'h600, 0, 1, 32'h5555_0500, 0,      0, P+32'h500, 0, P+32'h100, 32'h4444_0100, P+32'h500));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0,              1, P+32'h600, 0, P+32'h100, 32'h4444_0100, P+32'h600));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,                          1, 32'hFFFF_FFFC, 0, P+32'h100, 32'h4444_0100, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 0, 1, 32'h6666_FFFC, 0,              0, 32'hFFFF_FFFC, 0, P+32'h100, 32'h4444_0100, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,                          0, 32'h0, 1, 32'hFFFF_FFFC, 32'h6666_FFFC, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                          1, 32'h0, 0, 32'hFFFF_FFFC, 32'h6666_FFFC, 32'h0));

    // Reset values while rst is held low.
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst.req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.req_addr", imem_req_addr, P);
    chk("rst.out_pc", out_pc, 32'd0);
    chk("rst.out_inst", out_inst, 32'd0);
    chk("rst.pc", pc, P);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      chk($sformatf("v%0d.req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_reqv});
      chk($sformatf("v%0d.req_addr", i), imem_req_addr, vecs[i].e_addr);
      chk($sformatf("v%0d.out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      chk($sformatf("v%0d.out_pc", i), out_pc, vecs[i].e_opc);
      chk($sformatf("v%0d.out_inst", i), out_inst, vecs[i].e_inst);
      chk($sformatf("v%0d.pc", i), pc, vecs[i].e_pc);
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
      chk($sformatf("v%0d.out_err", i), {31'b0, out_err}, 32'd0);
`endif
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rsp;
      imem_rsp_data  = vecs[i].rdata;
      out_ready      = vecs[i].ordy;
      @(negedge clk);
    end

    // Zero-latency memory, IDU always ready: one beat every third cycle.
    do_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; out_ready = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    chk("tp.idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("tp.c%0d.out_valid", k), {31'b0, out_valid}, {31'b0, (k % 3) == 0});
      if (k == 1) begin
        chk("tp.first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("tp.first_req_addr", imem_req_addr, P);
      end
      if ((k % 3) == 0) begin
        chk($sformatf("tp.c%0d.out_pc", k), out_pc, P + 32'(4 * (k / 3 - 1)));
        chk($sformatf("tp.c%0d.out_inst", k), out_inst, 32'h0000_0013);
      end
    end
    // Steer into WAIT, then pulse reset asynchronously.
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rw.req_valid", {31'b0, imem_req_valid}, 32'd1);
    @(negedge clk);
    chk("rw.wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rw.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rw.req_valid_rst", {31'b0, imem_req_valid}, 32'd0);
    chk("rw.out_pc", out_pc, 32'd0);
    chk("rw.out_inst", out_inst, 32'd0);
    chk("rw.req_addr", imem_req_addr, P);
    chk("rw.pc", pc, P);
    @(negedge clk);
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    @(negedge clk);
    chk("rw.after_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rw.after_req_addr", imem_req_addr, P);

    // Misaligned redirect while a request is presented and not accepted.
    do_reset();
    @(negedge clk);
    chk("ma.req_valid", {31'b0, imem_req_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = P + 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0; redirect_pc = '0;
`ifdef YSYX_25060170_IFU_MISALIGN_CHK_EN
    chk("ma.err_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("ma.err_out_valid", {31'b0, out_valid}, 32'd1);
    chk("ma.err_flag", {31'b0, out_err}, 32'd1);
    chk("ma.err_out_pc", out_pc, P + 32'h102);
    chk("ma.err_out_inst", out_inst, 32'd0);
    @(negedge clk);
    chk("ma.err_hold_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ma.err_done_valid", {31'b0, out_valid}, 32'd0);
    chk("ma.err_done_flag", {31'b0, out_err}, 32'd0);
    @(negedge clk);
    chk("ma.err_stay_valid", {31'b0, out_valid}, 32'd0);
    chk("ma.err_stay_req", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = P + 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("ma.resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("ma.resume_req_addr", imem_req_addr, P + 32'h200);
`else
    chk("ma.req_valid_after", {31'b0, imem_req_valid}, 32'd1);
    chk("ma.req_addr", imem_req_addr, P + 32'h100);
    chk("ma.pc", pc, P + 32'h100);
    chk("ma.out_valid", {31'b0, out_valid}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
